// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter with grant hold for N requesters.
// A granted requester keeps the resource until it pulses done, drops its
// request, or reaches MAX_HOLD consecutive cycles. Every release passes
// through IDLE, so consecutive grants are separated by at least one idle
// cycle for bus turnaround. After a release, priority rotates to the index
// just after the last owner.

module rr_hold_arbiter #(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 16,
   localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   done,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           timeout
);

   // The counter must hold values 0..MAX_HOLD-1. When the timeout is
   // disabled it still needs at least one bit, and it saturates instead
   // of wrapping.
   localparam int             CW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
   localparam logic [CW-1:0]  CNT_SAT   = '1;
   localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);
   localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t         state_r;
   logic [IDW-1:0] ptr_r;
   logic [CW-1:0]  cnt_r;
   logic [N-1:0]   gnt_r;
   logic [IDW-1:0] gnt_id_r;
   logic           gnt_valid_r;
   logic           timeout_r;

   logic [IDW-1:0] sel_s;
   logic           any_req_s;
   logic           owner_done_s;
   logic           owner_req_s;
   logic           hold_hit_s;
   logic           release_s;
   logic           forced_s;
   logic [IDW-1:0] ptr_next_s;

   // Circular first-set search starting at p. Offsets are scanned from the
   // farthest to the nearest, so the nearest set bit is the last one written.
   // Indexes are reduced mod N, so an index >= N is never produced.
   function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   r,
                                              input logic [IDW-1:0] p);
      logic [IDW-1:0] pick;
      logic [IDW-1:0] idx;
      pick = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = IDW'((int'(p) + i) % N);
         if (r[idx]) begin
            pick = idx;
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   // Owner status, release decision and the rotated pointer for the next search.
   always_comb begin
      sel_s        = rr_pick(req, ptr_r);
      any_req_s    = |req;
      owner_done_s = done[gnt_id_r];
      owner_req_s  = req[gnt_id_r];
      hold_hit_s   = (MAX_HOLD > 0) && (cnt_r == HOLD_LAST);
      release_s    = owner_done_s | ~owner_req_s | hold_hit_s;
      // A forced release is one caused by the hold limit alone.
      forced_s     = hold_hit_s & ~owner_done_s & owner_req_s;
      ptr_next_s   = (gnt_id_r == LAST_ID) ? '0 : gnt_id_r + IDW'(1);
   end

   // Arbitration FSM. All outputs are registered here; reset has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         cnt_r       <= '0;
         gnt_r       <= '0;
         gnt_id_r    <= '0;
         gnt_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               timeout_r <= 1'b0;
               if (any_req_s) begin
                  // done is not looked at here, so a done pulse on the
                  // grant edge itself has no effect.
                  gnt_r       <= ONE_HOT0 << sel_s;
                  gnt_id_r    <= sel_s;
                  gnt_valid_r <= 1'b1;
                  cnt_r       <= '0;
                  state_r     <= GRANT;
               end else begin
                  gnt_r       <= '0;
                  gnt_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            GRANT: begin
               if (release_s) begin
                  // gnt_id keeps the last owner while gnt_valid is low.
                  gnt_r       <= '0;
                  gnt_valid_r <= 1'b0;
                  ptr_r       <= ptr_next_s;
                  cnt_r       <= '0;
                  timeout_r   <= forced_s;
                  state_r     <= IDLE;
               end else begin
                  cnt_r       <= (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CW'(1);
                  timeout_r   <= 1'b0;
                  state_r     <= GRANT;
               end
            end
            default: begin
               gnt_r       <= '0;
               gnt_valid_r <= 1'b0;
               timeout_r   <= 1'b0;
               cnt_r       <= '0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_r;
   assign gnt_id    = gnt_id_r;
   assign gnt_valid = gnt_valid_r;
   assign timeout   = timeout_r;

   rr_hold_arbiter_chk #(
      .N   (N),
      .IDW (IDW)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .gnt       (gnt_r),
      .gnt_id    (gnt_id_r),
      .gnt_valid (gnt_valid_r),
      .timeout   (timeout_r)
   );

endmodule

// rr_hold_arbiter_chk: output invariants of the arbiter.
module rr_hold_arbiter_chk #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input logic           clk,
   input logic           rst,
   input logic [N-1:0]   gnt,
   input logic [IDW-1:0] gnt_id,
   input logic           gnt_valid,
   input logic           timeout
);

   // Grant is never more than one-hot.
   a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

   // gnt_valid mirrors a non-zero grant.
   a_valid : assert property (@(posedge clk) disable iff (rst) gnt_valid == (gnt != '0));

   // While valid, gnt_id points at the granted bit and stays in range.
   a_id : assert property (@(posedge clk) disable iff (rst)
                           gnt_valid |-> (gnt[gnt_id] && (int'(gnt_id) < N)));

   // A timeout pulse always coincides with the idle turnaround cycle.
   a_timeout : assert property (@(posedge clk) disable iff (rst) timeout |-> !gnt_valid);

   // A new grant can only follow a cycle without one.
   a_turnaround : assert property (@(posedge clk) disable iff (rst)
                                   (gnt_valid && !$past(gnt_valid)) |-> ($past(gnt) == '0));

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed vectors for rr_hold_arbiter (N=4, MAX_HOLD=16).
// The driver applies one input vector per clock and queues the hand-derived
// output expected after that edge. A separate monitor pops the queue on the
// falling edge and compares it with the DUT outputs.

module tb_rr_hold_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 16;
   localparam int IDW      = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic           timeout;

   always #5 clk = ~clk;

   rr_hold_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   typedef struct {
      int             tst;
      logic [N-1:0]   gnt;
      logic [IDW-1:0] id;
      logic           v;
      logic           to;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   // Apply one vector, queue the output expected after the next rising edge.
   task automatic step(input int tst, input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] dn, input logic [N-1:0] eg,
                       input logic [IDW-1:0] eid, input logic ev, input logic eto);
      exp_t e;
      rst  = r;
      req  = rq;
      done = dn;
      e.tst = tst;
      e.gnt = eg;
      e.id  = eid;
      e.v   = ev;
      e.to  = eto;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the outputs of each cycle with the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (gnt !== e.gnt || gnt_id !== e.id || gnt_valid !== e.v || timeout !== e.to) begin
            failures++;
            $display("FAIL test%0d_outputs: got gnt=%b id=%0d valid=%b timeout=%b, expected gnt=%b id=%0d valid=%b timeout=%b",
                     e.tst, gnt, gnt_id, gnt_valid, timeout, e.gnt, e.id, e.v, e.to);
         end
      end
   end

   initial begin
      // 1: reset held with all requests up
      repeat (3) step(1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      // 2: full rotation, each owner holds 3 cycles then pulses done
      for (int o = 0; o < 4; o++) begin
         step(2, 1'b0, 4'b1111, 4'b0000, oh(o), 2'(o), 1'b1, 1'b0);
         repeat (2) step(2, 1'b0, 4'b1111, 4'b0000, oh(o), 2'(o), 1'b1, 1'b0);
         step(2, 1'b0, 4'b1111, oh(o), 4'b0000, 2'(o), 1'b0, 1'b0);
      end
      step(2, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      step(2, 1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      // 3: sole requester 2 runs into the hold limit
      step(3, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      repeat (15) step(3, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      step(3, 1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1);
      step(3, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      step(3, 1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
      step(3, 1'b0, 4'b1011, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);

      // 4: owner 1 drops its request in cycle 5, non-owner done ignored
      step(4, 1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
      step(4, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      step(4, 1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      step(4, 1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      step(4, 1'b0, 4'b1111, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0);
      step(4, 1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      step(4, 1'b0, 4'b1101, 4'b1000, 4'b0000, 2'd1, 1'b0, 1'b0);
      step(4, 1'b0, 4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);

      // 5: done coincides with the hold limit -> normal release
      repeat (15) step(5, 1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      step(5, 1'b0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
      step(5, 1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
      // done on the IDLE->GRANT edge is not seen
      step(5, 1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
      step(5, 1'b0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      step(5, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);

      // 6: reset mid-tenure of owner 2, pointer returns to 0
      step(6, 1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
      step(6, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      step(6, 1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      step(6, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      step(6, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      step(6, 1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);

      req  = 4'b0000;
      done = 4'b0000;
      for (int i = 0; i < 5 && sb.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
